pipeline_hazard_controller: RTL and testbench

//   Sequences the 5-stage pipeline (IF, ID, EX, MEM, WB) by driving the pipeline-register

---
 rtl/pipeline_hazard_controller_if.sv | 38 +++
 rtl/pipeline_hazard_controller.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the hazard controller and the pipeline-register chain.
// The pipeline side is the master (drives decode/memory status), the controller is the slave.
interface pipeline_hazard_controller_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_write_reg;
    logic              mem_pc_src;
    logic              mem_access;
    logic              dmem_ready;

    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              pipe_freeze;
    logic              mem_timeout;
    logic [15:0]       stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg,
               mem_pc_src, mem_access, dmem_ready,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, pipe_freeze, mem_timeout, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg,
               mem_pc_src, mem_access, dmem_ready,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, pipe_freeze, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline sequencer: load-use bubbles, taken-branch flushes and data-memory freeze.
// Control outputs are combinational from state + inputs; state, counters and flags are registered.
module pipeline_hazard_controller #(
    parameter int REG_AW       = 5,
    parameter int STALL_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  bus
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam logic [1:0] BUB_INIT = 2'(STALL_CYCLES - 1);
    localparam logic [3:0] WAIT_MAX = 4'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_bub;
    logic [1:0]  w_bub_nxt;
    logic [3:0]  r_wait;
    logic [15:0] r_stall_cnt;
    logic        r_timeout;

    logic w_hz;
    logic w_mwait;
    logic w_in_stall;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_bubble;
    logic w_flush;
    logic w_freeze;

    assign w_hz = bus.ex_mem_read && (bus.ex_write_reg != '0) &&
                  ((bus.ex_write_reg == bus.id_rs) ||
                   (bus.id_uses_rt && (bus.ex_write_reg == bus.id_rt)));
    assign w_mwait = bus.mem_access && !bus.dmem_ready;
    // A released MEM_WAIT resumes the stall if bubbles were still owed when it froze.
    assign w_in_stall = (r_state != RUN) && (r_bub != 2'd0);

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_freeze      = 1'b0;
        w_next        = RUN;
        w_bub_nxt     = r_bub;
        if (reset) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_flush       = 1'b1;
            w_bub_nxt     = 2'd0;
        end else if (w_mwait) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_freeze      = 1'b1;
            w_next        = MEM_WAIT;
        end else if (bus.mem_pc_src) begin
            w_flush       = 1'b1;
            w_bub_nxt     = 2'd0;
        end else if (w_in_stall) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_bub_nxt     = r_bub - 2'd1;
            w_next        = (r_bub == 2'd1) ? RUN : LOAD_STALL;
        end else if (w_hz) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_bub_nxt     = BUB_INIT;
            w_next        = (BUB_INIT != 2'd0) ? LOAD_STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_bub       <= 2'd0;
            r_wait      <= 4'd0;
            r_stall_cnt <= 16'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_bub   <= w_bub_nxt;
            if (w_mwait) begin
                if (r_wait != WAIT_MAX) r_wait <= r_wait + 4'd1;
                if (r_wait >= WAIT_MAX - 4'd1) r_timeout <= 1'b1;
            end else begin
                r_wait <= 4'd0;
            end
            if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.id_ex_bubble = w_bubble;
    assign bus.if_id_flush  = w_flush;
    assign bus.id_ex_flush  = w_flush;
    assign bus.ex_mem_flush = w_flush;
    assign bus.pipe_freeze  = w_freeze;
    assign bus.mem_timeout  = r_timeout;
    assign bus.stall_count  = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Random + directed bench for pipeline_hazard_controller against a bubble-debt reference model.
module tb_pipeline_hazard_controller;
    localparam int SC = 2;
    localparam int MT = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.REG_AW(5)) bus ();

    pipeline_hazard_controller #(
        .REG_AW(5), .STALL_CYCLES(SC), .MEM_TIMEOUT(MT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    // Model: bubbles still owed, consecutive wait cycles, sticky timeout, stall total.
    int m_pend = 0;
    int m_wcnt = 0;
    int m_stall = 0;
    bit m_to = 1'b0;
    logic [6:0] exp_v;
    logic [6:0] got_v;
    bit m_hz;
    bit m_wt;
    int rnd;
    int burst = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // {pc_write, if_id_write, bubble, if_id_flush, id_ex_flush, ex_mem_flush, freeze}
    always @(negedge clk) begin
        if (en) begin
            m_hz = bus.ex_mem_read && (bus.ex_write_reg != 0) &&
                   ((bus.ex_write_reg == bus.id_rs) || (bus.id_uses_rt && (bus.ex_write_reg == bus.id_rt)));
            m_wt = bus.mem_access && !bus.dmem_ready;
            if (reset)                   exp_v = 7'b0001110;
            else if (m_wt)               exp_v = 7'b0000001;
            else if (bus.mem_pc_src)     exp_v = 7'b1101110;
            else if (m_pend > 0 || m_hz) exp_v = 7'b0010000;
            else                         exp_v = 7'b1100000;
            got_v = {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.if_id_flush,
                     bus.id_ex_flush, bus.ex_mem_flush, bus.pipe_freeze};
            checks++;
            if (got_v !== exp_v || bus.stall_count !== 16'(m_stall) || bus.mem_timeout !== m_to) begin
                errors++;
                $display("FAIL model_cmp t=%0t ctl got=%b exp=%b stall got=%0h exp=%0h timeout got=%b exp=%b",
                         $time, got_v, exp_v, bus.stall_count, m_stall, bus.mem_timeout, m_to);
            end
            if (reset) begin
                m_pend = 0; m_wcnt = 0; m_stall = 0; m_to = 1'b0;
            end else begin
                if (m_wt) begin
                    if (m_wcnt < MT) m_wcnt++;
                    if (m_wcnt >= MT) m_to = 1'b1;
                end else begin
                    m_wcnt = 0;
                    if (bus.mem_pc_src) m_pend = 0;
                    else if (m_pend > 0) m_pend--;
                    else if (m_hz) m_pend = SC - 1;
                end
                if (exp_v[6] == 1'b0 && m_stall < 65535) m_stall++;
            end
        end
    end

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic mr, input logic [4:0] wr, input logic br, input logic ma,
                         input logic rdy);
        reset = r;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = urt;
        bus.ex_mem_read = mr; bus.ex_write_reg = wr;
        bus.mem_pc_src = br; bus.mem_access = ma; bus.dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic hazard(input logic r);
        drive(r, 5'd8, 5'd1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("rst_pc_write", 32'(bus.pc_write), 0);
        chk("rst_flushes", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 7);
        step();
        en = 1'b1;
        #3;
        chk("rst_stall_count", 32'(bus.stall_count), 0);
        chk("rst_timeout", 32'(bus.mem_timeout), 0);
        step();

        // Load r8 then consumer of r8: exactly two bubbles.
        hazard(1'b0); #3;
        chk("lu_bubble1", 32'({bus.id_ex_bubble, bus.pc_write}), 2);
        step(); #3;
        chk("lu_bubble2", 32'({bus.id_ex_bubble, bus.pc_write}), 2);
        step(); idle(); #3;
        chk("lu_resume", 32'({bus.id_ex_bubble, bus.pc_write}), 1);
        chk("lu_stall_count", 32'(bus.stall_count), 2);
        step();

        // Load writing r0 never stalls.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); #3;
        chk("r0_no_stall", 32'({bus.id_ex_bubble, bus.pc_write}), 1);
        step();

        // Branch during LOAD_STALL with one bubble left.
        hazard(1'b0); step();
        bus.mem_pc_src = 1'b1; #3;
        chk("br_flush", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.pc_write, bus.id_ex_bubble}), 5'b11110);
        step(); idle(); #3;
        chk("br_run", 32'({bus.pc_write, bus.id_ex_bubble}), 2);
        chk("br_stall_count", 32'(bus.stall_count), 3);
        step();

        // Four-cycle memory wait.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #3;
            chk("mw_freeze", 32'({bus.pipe_freeze, bus.pc_write}), 2);
            step();
        end
        bus.dmem_ready = 1'b1; #3;
        chk("mw_release", 32'({bus.pipe_freeze, bus.pc_write, bus.mem_timeout}), 3'b010);
        chk("mw_stall_count", 32'(bus.stall_count), 7);
        step();

        // Freeze during a load stall: the owed bubble resumes on release.
        hazard(1'b0); step();
        bus.mem_access = 1'b1; bus.dmem_ready = 1'b0; step(); step();
        bus.dmem_ready = 1'b1; #3;
        chk("mw_resume_bubble", 32'({bus.id_ex_bubble, bus.pc_write}), 2);
        step(); idle(); #3;
        chk("mw_resume_run", 32'({bus.id_ex_bubble, bus.pc_write}), 1);
        chk("mw_resume_count", 32'(bus.stall_count), 11);
        step();

        // Twenty-cycle wait: timeout after the fifteenth wait edge, sticky until reset.
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #3;
            if (k == 15 || k == 16) chk("to_edge", 32'(bus.mem_timeout), (k > MT) ? 1 : 0);
            step();
        end
        idle(); #3;
        chk("to_sticky", 32'(bus.mem_timeout), 1);
        step();
        reset = 1'b1; step(); idle(); #3;
        chk("to_cleared", 32'(bus.mem_timeout), 0);
        step();

        // Reset in LOAD_STALL.
        hazard(1'b0); step();
        reset = 1'b1; #3;
        chk("rst_mid_stall", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.pc_write, bus.id_ex_bubble}), 5'b11100);
        step(); idle(); #3;
        chk("rst_mid_after", 32'({bus.pc_write, bus.id_ex_bubble, 16'(bus.stall_count)}), 32'h20000);
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rnd = int'($urandom_range(0, 999));
            reset = (rnd < 5);
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.ex_mem_read = 1'($urandom_range(0, 1));
            bus.ex_write_reg = 5'($urandom_range(0, 3));
            bus.mem_pc_src = ($urandom_range(0, 9) == 0);
            bus.mem_access = ($urandom_range(0, 2) == 0);
            bus.dmem_ready = ($urandom_range(0, 2) != 0);
            if (burst > 0) begin
                bus.mem_access = 1'b1; bus.dmem_ready = 1'b0; burst--;
            end else if ($urandom_range(0, 199) == 0) begin
                burst = 18;
            end
            step();
        end

        // Long freeze: reach 0xFFFE in LOAD_STALL, then saturate.
        reset = 1'b1; step();
        drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 65533; k++) step();
        hazard(1'b0); bus.mem_access = 1'b1; step(); #3;
        chk("sat_fffe", 32'(bus.stall_count), 32'hFFFE);
        bus.dmem_ready = 1'b0;
        step(); step(); step();
        bus.mem_access = 1'b0; bus.dmem_ready = 1'b1; #3;
        chk("sat_hold", 32'(bus.stall_count), 32'hFFFF);
        chk("sat_resume_bubble", 32'(bus.id_ex_bubble), 1);
        step(); step();
        reset = 1'b1; #3;
        chk("sat_rst_flush", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.pc_write}), 4'b1110);
        step(); idle(); #3;
        chk("sat_rst_after", 32'({bus.pc_write, 16'(bus.stall_count)}), 32'h10000);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
